// File: rtl/wb_arbiter_pkg.sv
// Shared widths, the writeback entry type and a destination-decode helper for the
// register-file writeback arbiter.
package wb_arbiter_pkg;

  localparam int REG_ADDR_W     = 5;
  localparam int XLEN           = 64;
  localparam int NUM_REGS       = 32;
  localparam int STARVE_MAX_DEF = 3;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  // One-hot of a destination register; x0 never maps to a scoreboard bit.
  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    rd_onehot     = '0;
    rd_onehot[rd] = (rd != '0);
  endfunction

endpackage

// File: rtl/wb_arbiter_skid.sv
// One-entry valid/ready holding buffer for an MDU result awaiting the write port.
// The entry can be drained and refilled in the same cycle.
module wb_skid_buf
  import wb_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [REG_ADDR_W-1:0] i_addr,
  input  logic [XLEN-1:0]       i_data,
  input  logic                  i_pop,
  output logic                  o_valid,
  output logic [REG_ADDR_W-1:0] o_addr,
  output logic [XLEN-1:0]       o_data
);

  logic      valid_q, valid_d;
  wb_entry_t entry_q, entry_d;
  logic      load;

  assign o_ready = !valid_q || i_pop;
  assign load    = i_valid && o_ready && !i_flush;

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (i_pop) valid_d = 1'b0;
    if (load) begin
      valid_d      = 1'b1;
      entry_d.addr = i_addr;
      entry_d.data = i_data;
    end
    if (i_flush) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

  assign o_valid = valid_q;
  assign o_addr  = entry_q.addr;
  assign o_data  = entry_q.data;

endmodule

// File: rtl/wb_arbiter.sv
// Arbitrates the single reg_file write port between the pipeline WB stage and a
// skid-buffered MDU result, with bounded starvation and a pending-rd scoreboard.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int CNT_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic                  i_pipe_valid,
  output logic                  o_pipe_ready,
  input  logic                  i_pipe_rd_wen,
  input  logic [REG_ADDR_W-1:0] i_pipe_rd_addr,
  input  logic [XLEN-1:0]       i_pipe_rd_data,
  input  logic                  i_pipe_mem_read,
  input  logic [XLEN-1:0]       i_pipe_mem_rdata,
  input  logic                  i_mdu_issue,
  input  logic [REG_ADDR_W-1:0] i_mdu_issue_rd,
  input  logic                  i_mdu_valid,
  output logic                  o_mdu_ready,
  input  logic [REG_ADDR_W-1:0] i_mdu_rd_addr,
  input  logic [XLEN-1:0]       i_mdu_rd_data,
  output logic                  o_rd_wen,
  output logic [REG_ADDR_W-1:0] o_rd_addr,
  output logic [XLEN-1:0]       o_rd_wdata,
  output logic [NUM_REGS-1:0]   o_busy_mask
);

  logic                  skid_valid;
  logic [REG_ADDR_W-1:0] skid_addr;
  logic [XLEN-1:0]       skid_data;
  logic                  grant_skid, grant_pipe;
  logic [XLEN-1:0]       pipe_wdata;

  logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
  logic                  rd_wen_q, rd_wen_d;
  logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]       rd_wdata_q, rd_wdata_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;

  wb_skid_buf u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (i_flush),
    .i_valid (i_mdu_valid),
    .o_ready (o_mdu_ready),
    .i_addr  (i_mdu_rd_addr),
    .i_data  (i_mdu_rd_data),
    .i_pop   (grant_skid),
    .o_valid (skid_valid),
    .o_addr  (skid_addr),
    .o_data  (skid_data)
  );

  // The waiting MDU result wins when the pipe is idle or has won STARVE_MAX times in a row.
  assign grant_skid   = skid_valid && (!i_pipe_valid || (starve_cnt_q == CNT_W'(STARVE_MAX)));
  assign grant_pipe   = i_pipe_valid && !grant_skid;
  assign o_pipe_ready = !grant_skid;
  assign pipe_wdata   = i_pipe_mem_read ? i_pipe_mem_rdata : i_pipe_rd_data;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    rd_wen_d     = 1'b0;
    rd_addr_d    = rd_addr_q;
    rd_wdata_d   = rd_wdata_q;
    busy_d       = busy_q;

    if (!skid_valid || grant_skid) begin
      starve_cnt_d = '0;
    end else if (grant_pipe && (starve_cnt_q != CNT_W'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end

    if (grant_skid) begin
      rd_wen_d   = (skid_addr != '0);
      rd_addr_d  = skid_addr;
      rd_wdata_d = skid_data;
      busy_d     = busy_d & ~rd_onehot(skid_addr);
    end else if (grant_pipe) begin
      rd_wen_d   = i_pipe_rd_wen && (i_pipe_rd_addr != '0);
      rd_addr_d  = i_pipe_rd_addr;
      rd_wdata_d = pipe_wdata;
    end

    // A new issue to the same rd outranks the retiring write.
    if (i_mdu_issue) busy_d = busy_d | rd_onehot(i_mdu_issue_rd);

    if (i_flush) begin
      starve_cnt_d = '0;
      rd_wen_d     = 1'b0;
      rd_addr_d    = rd_addr_q;
      rd_wdata_d   = rd_wdata_q;
      busy_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      rd_wen_q     <= 1'b0;
      rd_addr_q    <= '0;
      rd_wdata_q   <= '0;
      busy_q       <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_wen_q     <= rd_wen_d;
      rd_addr_q    <= rd_addr_d;
      rd_wdata_q   <= rd_wdata_d;
      busy_q       <= busy_d;
    end
  end

  assign o_rd_wen    = rd_wen_q;
  assign o_rd_addr   = rd_addr_q;
  assign o_rd_wdata  = rd_wdata_q;
  assign o_busy_mask = busy_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scenario tasks plus a randomized run against a queue-based model of the
// writeback arbitration rules.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int SMAX = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_flush;
  logic        i_pipe_valid;
  logic        o_pipe_ready;
  logic        i_pipe_rd_wen;
  logic [4:0]  i_pipe_rd_addr;
  logic [63:0] i_pipe_rd_data;
  logic        i_pipe_mem_read;
  logic [63:0] i_pipe_mem_rdata;
  logic        i_mdu_issue;
  logic [4:0]  i_mdu_issue_rd;
  logic        i_mdu_valid;
  logic        o_mdu_ready;
  logic [4:0]  i_mdu_rd_addr;
  logic [63:0] i_mdu_rd_data;
  logic        o_rd_wen;
  logic [4:0]  o_rd_addr;
  logic [63:0] o_rd_wdata;
  logic [31:0] o_busy_mask;

  int tests = 0;
  int fails = 0;

  wb_arbiter #(.STARVE_MAX(SMAX), .CNT_W(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_flush          (i_flush),
    .i_pipe_valid     (i_pipe_valid),
    .o_pipe_ready     (o_pipe_ready),
    .i_pipe_rd_wen    (i_pipe_rd_wen),
    .i_pipe_rd_addr   (i_pipe_rd_addr),
    .i_pipe_rd_data   (i_pipe_rd_data),
    .i_pipe_mem_read  (i_pipe_mem_read),
    .i_pipe_mem_rdata (i_pipe_mem_rdata),
    .i_mdu_issue      (i_mdu_issue),
    .i_mdu_issue_rd   (i_mdu_issue_rd),
    .i_mdu_valid      (i_mdu_valid),
    .o_mdu_ready      (o_mdu_ready),
    .i_mdu_rd_addr    (i_mdu_rd_addr),
    .i_mdu_rd_data    (i_mdu_rd_data),
    .o_rd_wen         (o_rd_wen),
    .o_rd_addr        (o_rd_addr),
    .o_rd_wdata       (o_rd_wdata),
    .o_busy_mask      (o_busy_mask)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_flush = 0; i_pipe_valid = 0; i_pipe_rd_wen = 0; i_pipe_rd_addr = 0;
    i_pipe_rd_data = 0; i_pipe_mem_read = 0; i_pipe_mem_rdata = 0;
    i_mdu_issue = 0; i_mdu_issue_rd = 0; i_mdu_valid = 0; i_mdu_rd_addr = 0; i_mdu_rd_data = 0;
  endtask

  task automatic pipe(input logic [4:0] a, input logic [63:0] d);
    i_pipe_valid = 1; i_pipe_rd_wen = 1; i_pipe_rd_addr = a;
    i_pipe_rd_data = d; i_pipe_mem_read = 0;
  endtask

  task automatic test_reset();
    tests++;
    if ({o_rd_wen, o_rd_addr, o_rd_wdata, o_busy_mask} !== '0) begin
      fails++; $display("FAIL reset_init: got wen=%0b addr=%0d data=%0h busy=%0h required all 0", o_rd_wen, o_rd_addr, o_rd_wdata, o_busy_mask);
    end
    tick(); rst_n = 1;
    tick();
    i_mdu_issue = 1; i_mdu_issue_rd = 10;
    i_mdu_valid = 1; i_mdu_rd_addr = 10; i_mdu_rd_data = 64'h77;
    pipe(5'd3, 64'h33);
    tick();
    i_mdu_issue = 0; i_mdu_valid = 0;
    #1;
    tests++;
    if (o_busy_mask !== 32'h400 || o_mdu_ready !== 1'b0 || o_rd_wen !== 1'b1) begin
      fails++; $display("FAIL reset_pre: got busy=%0h mdu_ready=%0b wen=%0b required 400 0 1", o_busy_mask, o_mdu_ready, o_rd_wen);
    end
    #1 rst_n = 0;
    #1;
    tests++;
    if ({o_rd_wen, o_rd_addr, o_rd_wdata, o_busy_mask} !== '0) begin
      fails++; $display("FAIL reset_async: got wen=%0b addr=%0d data=%0h busy=%0h required all 0", o_rd_wen, o_rd_addr, o_rd_wdata, o_busy_mask);
    end
    idle();
    @(posedge clk); #1 rst_n = 1;
    #1;
    tests++;
    if (o_mdu_ready !== 1'b1 || o_pipe_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready: got mdu_ready=%0b pipe_ready=%0b required 1 1", o_mdu_ready, o_pipe_ready);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (o_rd_wen !== 1'b0 || o_busy_mask !== '0) begin
        fails++; $display("FAIL reset_drop: got wen=%0b busy=%0h required 0 0", o_rd_wen, o_busy_mask);
      end
    end
  endtask

  task automatic test_pipe_only();
    pipe(5'd5, 64'h1); i_pipe_mem_read = 1; i_pipe_mem_rdata = 64'hDEAD;
    #1;
    tests++;
    if (o_pipe_ready !== 1'b1) begin
      fails++; $display("FAIL pipe_ready: got %0b required 1", o_pipe_ready);
    end
    tick();
    pipe(5'd6, 64'h1234);
    tests++;
    if (o_rd_wen !== 1'b1 || o_rd_addr !== 5'd5 || o_rd_wdata !== 64'hDEAD) begin
      fails++; $display("FAIL pipe_load: got wen=%0b addr=%0d data=%0h required 1 5 dead", o_rd_wen, o_rd_addr, o_rd_wdata);
    end
    tick();
    pipe(5'd0, 64'h99);
    tests++;
    if (o_rd_wen !== 1'b1 || o_rd_addr !== 5'd6 || o_rd_wdata !== 64'h1234) begin
      fails++; $display("FAIL pipe_alu: got wen=%0b addr=%0d data=%0h required 1 6 1234", o_rd_wen, o_rd_addr, o_rd_wdata);
    end
    #1;
    tests++;
    if (o_pipe_ready !== 1'b1) begin
      fails++; $display("FAIL pipe_x0_ready: got %0b required 1", o_pipe_ready);
    end
    tick();
    pipe(5'd9, 64'h5); i_pipe_rd_wen = 0;
    tests++;
    if (o_rd_wen !== 1'b0) begin
      fails++; $display("FAIL pipe_x0_wen: got %0b required 0", o_rd_wen);
    end
    tick();
    idle();
    tests++;
    if (o_rd_wen !== 1'b0 || o_rd_addr !== 5'd9) begin
      fails++; $display("FAIL pipe_nowen: got wen=%0b addr=%0d required 0 9", o_rd_wen, o_rd_addr);
    end
    tick();
    tests++;
    if (o_rd_wen !== 1'b0 || o_rd_addr !== 5'd9 || o_rd_wdata !== 64'h5) begin
      fails++; $display("FAIL pipe_hold: got wen=%0b addr=%0d data=%0h required 0 9 5", o_rd_wen, o_rd_addr, o_rd_wdata);
    end
  endtask

  task automatic test_starvation();
    i_mdu_issue = 1; i_mdu_issue_rd = 10;
    i_mdu_valid = 1; i_mdu_rd_addr = 10; i_mdu_rd_data = 64'h77;
    pipe(5'd1, 64'h100);
    tick();
    i_mdu_issue = 0; i_mdu_valid = 0;
    for (int k = 0; k < SMAX; k++) begin
      pipe(5'(2 + k), 64'h200 + 64'(k));
      #1;
      tests++;
      if (o_pipe_ready !== 1'b1) begin
        fails++; $display("FAIL starve_pready_%0d: got %0b required 1", k, o_pipe_ready);
      end
      tick();
      tests++;
      if (o_rd_wen !== 1'b1 || o_rd_addr !== 5'(2 + k) || o_busy_mask[10] !== 1'b1) begin
        fails++; $display("FAIL starve_pipe_%0d: got wen=%0b addr=%0d busy10=%0b required 1 %0d 1", k, o_rd_wen, o_rd_addr, o_busy_mask[10], 2 + k);
      end
    end
    pipe(5'd9, 64'h900);
    #1;
    tests++;
    if (o_pipe_ready !== 1'b0 || o_mdu_ready !== 1'b1) begin
      fails++; $display("FAIL starve_force: got pipe_ready=%0b mdu_ready=%0b required 0 1", o_pipe_ready, o_mdu_ready);
    end
    tick();
    tests++;
    if (o_rd_wen !== 1'b1 || o_rd_addr !== 5'd10 || o_rd_wdata !== 64'h77 || o_busy_mask[10] !== 1'b0) begin
      fails++; $display("FAIL starve_mdu_wr: got wen=%0b addr=%0d data=%0h busy10=%0b required 1 10 77 0", o_rd_wen, o_rd_addr, o_rd_wdata, o_busy_mask[10]);
    end
    tests++;
    if (o_pipe_ready !== 1'b1) begin
      fails++; $display("FAIL starve_resume: got %0b required 1", o_pipe_ready);
    end
    tick();
    idle();
    tests++;
    if (o_rd_wen !== 1'b1 || o_rd_addr !== 5'd9 || o_rd_wdata !== 64'h900) begin
      fails++; $display("FAIL starve_pipe_after: got wen=%0b addr=%0d data=%0h required 1 9 900", o_rd_wen, o_rd_addr, o_rd_wdata);
    end
  endtask

  task automatic test_mdu_latency();
    i_mdu_valid = 1; i_mdu_rd_addr = 12; i_mdu_rd_data = 64'hAA;
    #1;
    tests++;
    if (o_mdu_ready !== 1'b1) begin
      fails++; $display("FAIL lat_ready0: got %0b required 1", o_mdu_ready);
    end
    tick();
    i_mdu_rd_addr = 13; i_mdu_rd_data = 64'hBB;
    #1;
    tests++;
    if (o_mdu_ready !== 1'b1 || o_pipe_ready !== 1'b0 || o_rd_wen !== 1'b0) begin
      fails++; $display("FAIL lat_refill: got mdu_ready=%0b pipe_ready=%0b wen=%0b required 1 0 0", o_mdu_ready, o_pipe_ready, o_rd_wen);
    end
    tick();
    i_mdu_valid = 0;
    tests++;
    if (o_rd_wen !== 1'b1 || o_rd_addr !== 5'd12 || o_rd_wdata !== 64'hAA) begin
      fails++; $display("FAIL lat_first: got wen=%0b addr=%0d data=%0h required 1 12 aa", o_rd_wen, o_rd_addr, o_rd_wdata);
    end
    tick();
    tests++;
    if (o_rd_wen !== 1'b1 || o_rd_addr !== 5'd13 || o_rd_wdata !== 64'hBB) begin
      fails++; $display("FAIL lat_second: got wen=%0b addr=%0d data=%0h required 1 13 bb", o_rd_wen, o_rd_addr, o_rd_wdata);
    end
    tick();
    tests++;
    if (o_rd_wen !== 1'b0) begin
      fails++; $display("FAIL lat_drain: got %0b required 0", o_rd_wen);
    end
  endtask

  task automatic test_set_clear_same();
    i_mdu_issue = 1; i_mdu_issue_rd = 7;
    i_mdu_valid = 1; i_mdu_rd_addr = 7; i_mdu_rd_data = 64'h55;
    tick();
    i_mdu_valid = 0;
    tests++;
    if (o_busy_mask !== 32'h80) begin
      fails++; $display("FAIL sc_set: got busy=%0h required 80", o_busy_mask);
    end
    tick();
    idle();
    tests++;
    if (o_rd_wen !== 1'b1 || o_rd_addr !== 5'd7 || o_busy_mask[7] !== 1'b1) begin
      fails++; $display("FAIL sc_same: got wen=%0b addr=%0d busy7=%0b required 1 7 1", o_rd_wen, o_rd_addr, o_busy_mask[7]);
    end
    tick();
    tests++;
    if (o_busy_mask !== 32'h80) begin
      fails++; $display("FAIL sc_keep: got busy=%0h required 80", o_busy_mask);
    end
  endtask

  task automatic test_flush();
    i_mdu_issue = 1; i_mdu_issue_rd = 2;
    i_mdu_valid = 1; i_mdu_rd_addr = 2; i_mdu_rd_data = 64'h99;
    pipe(5'd4, 64'h44);
    tick();
    i_mdu_valid = 0;
    tests++;
    if (o_busy_mask !== 32'h84) begin
      fails++; $display("FAIL flush_pre: got busy=%0h required 84", o_busy_mask);
    end
    i_flush = 1; i_mdu_issue = 1; i_mdu_issue_rd = 9;
    pipe(5'd5, 64'h55);
    tick();
    idle();
    tests++;
    if (o_busy_mask !== '0 || o_rd_wen !== 1'b0) begin
      fails++; $display("FAIL flush_next: got busy=%0h wen=%0b required 0 0", o_busy_mask, o_rd_wen);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      tests++;
      if (o_rd_wen !== 1'b0 || o_busy_mask !== '0) begin
        fails++; $display("FAIL flush_quiet_%0d: got wen=%0b busy=%0h required 0 0", k, o_rd_wen, o_busy_mask);
      end
    end
  endtask

  task automatic test_random();
    wb_entry_t   m_skid[$];
    wb_entry_t   ent;
    int          m_wins;
    logic [31:0] m_busy;
    logic        e_wen;
    logic [4:0]  e_addr;
    logic [63:0] e_data;
    logic        src_pend;
    logic [4:0]  src_addr;
    logic [63:0] src_data;
    logic        waiting, forced, exp_pready, exp_mready;

    idle(); i_flush = 1; tick();
    idle(); pipe(5'd3, 64'h3); tick();
    idle();
    m_skid.delete(); m_wins = 0; m_busy = '0;
    e_wen = 1; e_addr = 3; e_data = 64'h3;
    src_pend = 0; src_addr = 0; src_data = 0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      i_flush          = ($urandom_range(0, 29) == 0);
      i_pipe_valid     = ($urandom_range(0, 9) < 7);
      i_pipe_rd_wen    = ($urandom_range(0, 5) != 0);
      i_pipe_rd_addr   = 5'($urandom_range(0, 31));
      i_pipe_rd_data   = {$urandom, $urandom};
      i_pipe_mem_read  = 1'($urandom_range(0, 1));
      i_pipe_mem_rdata = {$urandom, $urandom};
      if (!src_pend && $urandom_range(0, 9) < 4) begin
        src_pend = 1; src_addr = 5'($urandom_range(0, 31)); src_data = {$urandom, $urandom};
      end
      i_mdu_valid = src_pend; i_mdu_rd_addr = src_addr; i_mdu_rd_data = src_data;
      i_mdu_issue = ($urandom_range(0, 9) < 3);
      i_mdu_issue_rd = 5'($urandom_range(0, 31));
      #1;
      waiting    = (m_skid.size() != 0);
      forced     = waiting && (!i_pipe_valid || m_wins >= SMAX);
      exp_pready = !forced;
      exp_mready = !waiting || forced;
      tests++;
      if (o_pipe_ready !== exp_pready || o_mdu_ready !== exp_mready) begin
        fails++; $display("FAIL rand_ready cyc %0d: got pipe=%0b mdu=%0b required %0b %0b", cyc, o_pipe_ready, o_mdu_ready, exp_pready, exp_mready);
      end
      if (i_flush) begin
        m_skid.delete(); m_wins = 0; m_busy = '0; e_wen = 0;
      end else begin
        if (forced) begin
          ent = m_skid.pop_front();
          e_wen = (ent.addr != 0); e_addr = ent.addr; e_data = ent.data;
          m_busy[ent.addr] = 1'b0;
          m_wins = 0;
        end else if (i_pipe_valid) begin
          e_wen  = i_pipe_rd_wen && (i_pipe_rd_addr != 0);
          e_addr = i_pipe_rd_addr;
          e_data = i_pipe_mem_read ? i_pipe_mem_rdata : i_pipe_rd_data;
          m_wins = waiting ? ((m_wins < SMAX) ? m_wins + 1 : SMAX) : 0;
        end else begin
          e_wen = 0; m_wins = 0;
        end
        if (i_mdu_valid && exp_mready) m_skid.push_back('{addr: src_addr, data: src_data});
        if (i_mdu_issue && i_mdu_issue_rd != 0) m_busy[i_mdu_issue_rd] = 1'b1;
      end
      if (i_mdu_valid && (exp_mready || i_flush)) src_pend = 0;
      tick();
      tests++;
      if (o_rd_wen !== e_wen || o_rd_addr !== e_addr || o_rd_wdata !== e_data || o_busy_mask !== m_busy) begin
        fails++; $display("FAIL rand_wr cyc %0d: got wen=%0b addr=%0d data=%0h busy=%0h required %0b %0d %0h %0h", cyc, o_rd_wen, o_rd_addr, o_rd_wdata, o_busy_mask, e_wen, e_addr, e_data, m_busy);
      end
    end
    idle();
  endtask

  initial begin
    rst_n = 0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_pipe_only();
    test_starvation();
    test_mdu_latency();
    test_set_clear_same();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Sequences the single register-file write port between two writeback sources:
  - the in-order pipeline WB stage, which includes the load-data select;
  - the multi-cycle mul/div unit (MDU).
- Holds one MDU result in a skid buffer and arbitrates it against the pipeline with a bounded-starvation policy.
- Keeps a 32-bit pending-destination scoreboard for decode hazard checks.
- Sits between the WB stage / MDU and the reg_file write port.

Parameters:
- STARVE_MAX, 3, max consecutive pipeline grants while an MDU result waits; at this count the skid is forced through.
- CNT_W, 2, width of the starvation counter; must hold STARVE_MAX.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- i_flush  input  1  pipeline flush; MDU is flushed in the same cycle.
- i_pipe_valid  input  1  pipeline WB holds a retiring instruction.
- o_pipe_ready  output  1  pipeline writeback accepted this cycle.
- i_pipe_rd_wen  input  1  pipeline instruction writes rd.
- i_pipe_rd_addr  input  5  pipeline destination.
- i_pipe_rd_data  input  64  ALU/CSR result.
- i_pipe_mem_read  input  1  instruction is a load.
- i_pipe_mem_rdata  input  64  load data.
- i_mdu_issue  input  1  MDU op issued this cycle.
- i_mdu_issue_rd  input  5  its destination.
- i_mdu_valid  input  1  MDU result available.
- o_mdu_ready  output  1  skid can take the MDU result.
- i_mdu_rd_addr  input  5  MDU result destination.
- i_mdu_rd_data  input  64  MDU result.
- o_rd_wen  output  1  reg_file write enable (registered).
- o_rd_addr  output  5  reg_file write address (registered).
- o_rd_wdata  output  64  reg_file write data (registered).
- o_busy_mask  output  32  bit r set = rd r awaits an MDU writeback.

Behaviour:
- Reset (rst_n low, async): o_rd_wen=0, o_rd_addr=0, o_rd_wdata=0, o_busy_mask=0, skid empty, starve_cnt=0. Reset mid-MDU-op drops all in-flight state.
- Pipeline data select: i_pipe_mem_read ? i_pipe_mem_rdata : i_pipe_rd_data.
- Grant is combinational in the current cycle:
  - grant_skid = skid_valid && (!i_pipe_valid || starve_cnt == STARVE_MAX);
  - grant_pipe = i_pipe_valid && !grant_skid.
- o_pipe_ready = !grant_skid. Pipeline transfer occurs when i_pipe_valid && o_pipe_ready.
- o_mdu_ready = !skid_valid || grant_skid, so the skid is freed and refilled in the same cycle. MDU transfer occurs when i_mdu_valid && o_mdu_ready.
- Write port, registered with 1-cycle latency:
  - pipe transfer in cycle N: o_rd_* in N+1, o_rd_wen = i_pipe_rd_wen;
  - skid grant in N: o_rd_* in N+1, o_rd_wen = 1;
  - neither: o_rd_wen=0 in N+1; addr/data hold their previous values.
- x0: o_rd_wen forced 0 whenever the selected addr is 0. The handshake still completes.
- MDU latency: accepted into skid in cycle N, earliest grant N+1, earliest write N+2.
- starve_cnt:
  - +1 when skid_valid && grant_pipe, saturating at STARVE_MAX;
  - cleared on grant_skid or when the skid is empty.
- Scoreboard:
  - i_mdu_issue sets bit i_mdu_issue_rd (never bit 0);
  - grant_skid clears the skid's rd bit at the write cycle, not at skid capture.
  - Set and clear of the same bit in one cycle: set wins.
- Flush (i_flush=1):
  - next cycle skid empty, starve_cnt=0, o_busy_mask=0, o_rd_wen=0;
  - pipe/MDU transfers in the flush cycle are discarded;
  - an issue in the flush cycle is ignored.
  - Flush has priority over all other events.
- Skid stays full with no loss while o_mdu_ready=0. The MDU must hold i_mdu_valid and its data stable until accepted.

Decomposition:
- Shared package / defines.v: REG_ADDR_W=5, XLEN=64, NUM_REGS=32, STARVE_MAX default.
- One natural sub-module: wb_skid_buf, a 1-entry valid/ready buffer holding addr+data.
- Arbitration, the output register and the scoreboard stay in the top level.

Test Plan:
1. Reset asserted mid-run with skid full and busy_mask=0x0000_0400 -> all outputs 0 immediately; after release o_mdu_ready=1, o_pipe_ready=1.
2. Pipe only: valid, rd=5, mem_read=1, rdata=0xDEAD, rd_data=0x1 -> next cycle o_rd_wen=1, addr=5, wdata=0xDEAD; with rd=0 -> o_rd_wen=0, handshake still completes.
3. Starvation: issue rd=10 (busy bit 10 set), MDU result 0x77 into skid, pipe valid continuously -> 3 pipe grants, then o_pipe_ready=0 for one cycle, MDU write rd=10 data 0x77, bit 10 cleared that cycle.
4. Pipe idle: MDU valid in cycle N -> skid granted N+1, o_rd_wen=1 in N+2; second MDU result accepted in N+1 (o_mdu_ready=1 with skid full).
5. Issue rd=7 in the same cycle a pending rd=7 is written from the skid -> bit 7 remains set.
6. Flush with skid full and busy_mask=0x0000_0084 -> next cycle busy_mask=0, o_rd_wen=0, no MDU write ever appears.
